bcd_count_display: RTL and testbench

Parametrised N-digit BCD up/down counter with a time-multiplexed seven-segment driver, all in one clock domain. It replaces the fixed two-digit 00–99 counter top. Internal tick enables replace the divided clocks, and the block adds programmable modulo, up/down counting, synchronous load and leading-zero blanking. It sits directly on the board pins: segment bus, digit select, decimal point, LED common and carry LED.

---
 rtl/bcd_count_display_pkg.sv | 51 +++++
 rtl/bcd_digit_updown.sv | 31 +++
 rtl/bcd_count_display.sv | 142 ++++++++++++++
 tb/tb_bcd_count_display.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_count_display_pkg.sv
// Shared types, segment codes and helpers for the BCD counter/display block.
package bcd_count_display_pkg;

  typedef logic [3:0] bcd_t;

  // Segment order {a,b,c,d,e,f,g}, active high.
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Widest BCD image we ever need: 6 digits plus one for MODULO = 10^6.
  localparam int BCD_W = 28;

  function automatic logic [6:0] seg7_decode(input bcd_t d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Elaboration-time conversion of an integer to packed BCD (digit 0 in [3:0]).
  function automatic logic [BCD_W-1:0] int_to_bcd(input int unsigned v);
    logic [BCD_W-1:0] r;
    int unsigned      t;
    r = '0;
    t = v;
    for (int i = 0; i < BCD_W / 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t           = t / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_updown.sv
// One BCD digit of the up/down counter: load, forced wrap value, or ripple step.
module bcd_digit_updown
  import bcd_count_display_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic step_in,
  input  logic up_dn,
  input  logic load,
  input  bcd_t load_digit,
  input  logic wrap,
  input  bcd_t wrap_digit,
  output bcd_t digit,
  output logic step_out
);

  // Carry out on 9 going up, borrow out on 0 going down.
  assign step_out = step_in & (up_dn ? (digit == 4'd9) : (digit == 4'd0));

  // Load beats the modulo wrap, which beats a normal ripple step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        digit <= 4'd0;
    else if (load)    digit <= load_digit;
    else if (wrap)    digit <= wrap_digit;
    else if (step_in) begin
      if (up_dn) digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
      else       digit <= (digit == 4'd0) ? 4'd9 : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_count_display.sv
// N-digit BCD up/down counter with programmable modulo and a multiplexed
// seven-segment driver with optional leading-zero blanking.
module bcd_count_display
  import bcd_count_display_pkg::*;
#(
  parameter int         DIGITS   = 2,
  parameter int         MODULO   = 100,
  parameter int         CNT_DIV  = 21,
  parameter int         SCAN_DIV = 17,
  parameter logic [2:0] SEL_LSD  = 3'd5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  blank_lz,
  output logic [2:0]            seg7_sel,
  output logic [6:0]            seg7_out,
  output logic                  dpt_out,
  output logic                  led_com,
  output logic                  carry,
  output logic [4*DIGITS-1:0]   count_bcd
);

  localparam int               W         = 4 * DIGITS;
  localparam logic [BCD_W-1:0] MAX_BCD28 = int_to_bcd(MODULO - 1);
  localparam logic [BCD_W-1:0] MOD_BCD28 = int_to_bcd(MODULO);
  localparam logic [W-1:0]     MAX_BCD   = MAX_BCD28[W-1:0];
  // A full-range counter (MODULO = 10^DIGITS) wraps naturally through the ripple.
  localparam bit               FULL_RNG  = (MOD_BCD28 == (BCD_W'(1) << W));

  logic [CNT_DIV-1:0]       cnt_pre;
  logic [SCAN_DIV-1:0]      scan_pre;
  logic                     cnt_tick;
  logic                     scan_tick;
  logic [DIGITS-1:0][3:0]   dig;
  logic [DIGITS:0]          step;
  logic                     adv;
  logic                     at_term;
  logic                     do_wrap;
  logic [W-1:0]             wrap_val;
  logic                     ld_ok;
  logic [W-1:0]             ld_val;
  logic [2:0]               scan_idx;
  logic [2:0]               idx_nxt;
  logic [DIGITS-1:0]        lz;
  bcd_t                     cur_digit;
  logic                     cur_blank;

  // Free-running prescalers; load never touches them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_pre  <= '0;
      scan_pre <= '0;
    end else begin
      cnt_pre  <= cnt_pre + CNT_DIV'(1);
      scan_pre <= scan_pre + SCAN_DIV'(1);
    end
  end

  assign cnt_tick  = &cnt_pre;
  assign scan_tick = &scan_pre;

  // Terminal value depends on direction; carry flags it while counting is enabled.
  assign at_term  = up_dn ? (dig == MAX_BCD) : (dig == '0);
  assign carry    = enable & at_term;
  assign adv      = cnt_tick & enable;
  assign wrap_val = up_dn ? '0 : MAX_BCD;
  assign do_wrap  = adv & at_term & ~(FULL_RNG & step[DIGITS]);
  assign step[0]  = adv;

  // Reject loads with a non-decimal digit or a value outside the modulo range.
  always_comb begin
    ld_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (load_val[4*i +: 4] > 4'd9) ld_ok = 1'b0;
    if ({{(BCD_W-W){1'b0}}, load_val} >= MOD_BCD28) ld_ok = 1'b0;
    ld_val = ld_ok ? load_val : '0;
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit_updown u_dig (
      .clk        (clk),
      .reset      (reset),
      .step_in    (step[g]),
      .up_dn      (up_dn),
      .load       (load),
      .load_digit (ld_val[4*g +: 4]),
      .wrap       (do_wrap),
      .wrap_digit (wrap_val[4*g +: 4]),
      .digit      (dig[g]),
      .step_out   (step[g+1])
    );
  end

  assign count_bcd = dig;

  // Scan index the registers will hold after this edge.
  always_comb begin
    idx_nxt = scan_idx;
    if (scan_tick) idx_nxt = (scan_idx == 3'(DIGITS - 1)) ? 3'd0 : scan_idx + 3'd1;
  end

  // lz[i]: digit i and every digit above it are zero.
  always_comb begin
    lz             = '0;
    lz[DIGITS-1]   = (dig[DIGITS-1] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--)
      lz[i] = lz[i+1] & (dig[i] == 4'd0);
  end

  // Select the digit to show; digit 0 is never blanked.
  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_nxt == 3'(i)) begin
        cur_digit = dig[i];
        cur_blank = blank_lz & lz[i] & (i > 0);
      end
    end
  end

  // Display outputs are fully registered and advance together with scan_idx.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_idx <= 3'd0;
      seg7_sel <= SEL_LSD;
      seg7_out <= SEG_0;
    end else begin
      scan_idx <= idx_nxt;
      seg7_sel <= SEL_LSD - idx_nxt;
      seg7_out <= cur_blank ? SEG_BLANK : seg7_decode(cur_digit);
    end
  end

  assign dpt_out = 1'b0;
  assign led_com = 1'b1;

endmodule

// File: tb/tb_bcd_count_display.sv
// Bench: three configurations (2-digit mod 100, 2-digit mod 60, 3-digit mod 1000)
// run side by side against an arithmetic reference model.
module tb_bcd_count_display;

  localparam int         ND = 3;
  localparam int         M [ND] = '{100, 60, 1000};
  localparam int         D [ND] = '{2, 2, 3};
  localparam logic [6:0] SEGT [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                       7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                       7'b1111111, 7'b1111011};

  logic clk = 1'b0;
  logic reset, enable, up_dn, load, blank_lz;
  logic [7:0]  lv_a, lv_b, cnt_a, cnt_b;
  logic [11:0] lv_c, cnt_c;
  logic [ND-1:0][2:0] sel;
  logic [ND-1:0][6:0] seg;
  logic [ND-1:0]      dpt, com, cy;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  // Reference model state
  int         edge_n = 0;
  int         mc   [ND] = '{0, 0, 0};
  int         midx [ND] = '{0, 0, 0};
  logic [6:0] mseg [ND] = '{7'b1111110, 7'b1111110, 7'b1111110};

  always #5 clk = ~clk;

  bcd_count_display #(.DIGITS(2), .MODULO(100), .CNT_DIV(2), .SCAN_DIV(1), .SEL_LSD(3'd5)) u_a (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load), .load_val(lv_a),
    .blank_lz(blank_lz), .seg7_sel(sel[0]), .seg7_out(seg[0]), .dpt_out(dpt[0]),
    .led_com(com[0]), .carry(cy[0]), .count_bcd(cnt_a));

  bcd_count_display #(.DIGITS(2), .MODULO(60), .CNT_DIV(2), .SCAN_DIV(1), .SEL_LSD(3'd5)) u_b (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load), .load_val(lv_b),
    .blank_lz(blank_lz), .seg7_sel(sel[1]), .seg7_out(seg[1]), .dpt_out(dpt[1]),
    .led_com(com[1]), .carry(cy[1]), .count_bcd(cnt_b));

  bcd_count_display #(.DIGITS(3), .MODULO(1000), .CNT_DIV(2), .SCAN_DIV(1), .SEL_LSD(3'd5)) u_c (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load), .load_val(lv_c),
    .blank_lz(blank_lz), .seg7_sel(sel[2]), .seg7_out(seg[2]), .dpt_out(dpt[2]),
    .led_com(com[2]), .carry(cy[2]), .count_bcd(cnt_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pow10(input int n);
    int r = 1;
    for (int k = 0; k < n; k++) r *= 10;
    return r;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    for (int k = 0; k < 3; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  function automatic logic [11:0] lv_of(input int i);
    case (i)
      0:       return {4'h0, lv_a};
      1:       return {4'h0, lv_b};
      default: return lv_c;
    endcase
  endfunction

  function automatic logic [11:0] cnt_of(input int i);
    case (i)
      0:       return {4'h0, cnt_a};
      1:       return {4'h0, cnt_b};
      default: return cnt_c;
    endcase
  endfunction

  // Loaded value as a number; anything non-decimal or out of range becomes 0.
  function automatic int ld_model(input int i);
    logic [11:0] v;
    int          n;
    v = lv_of(i);
    n = 0;
    for (int k = 0; k < D[i]; k++) begin
      if (v[4*k +: 4] > 4'd9) return 0;
      n += int'(v[4*k +: 4]) * pow10(k);
    end
    return (n >= M[i]) ? 0 : n;
  endfunction

  function automatic logic [6:0] exp_seg(input int c, input int idx);
    int hi;
    hi = c / pow10(idx);
    if (blank_lz && idx > 0 && hi == 0) return 7'b0000000;
    return SEGT[hi % 10];
  endfunction

  // Model: count edges every 4th clk after reset, scan edges every 2nd.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      edge_n = 0;
      for (int i = 0; i < ND; i++) begin
        mc[i] = 0; midx[i] = 0; mseg[i] = 7'b1111110;
      end
    end else begin
      edge_n++;
      for (int i = 0; i < ND; i++) begin
        if (edge_n % 2 == 0) midx[i] = (midx[i] + 1) % D[i];
        mseg[i] = exp_seg(mc[i], midx[i]);
        if (load) mc[i] = ld_model(i);
        else if (edge_n % 4 == 0 && enable)
          mc[i] = up_dn ? (mc[i] + 1) % M[i] : (mc[i] + M[i] - 1) % M[i];
      end
    end
  end

  // Continuous comparison against the model, just after each active edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (!reset && chk_on) begin
      for (int i = 0; i < ND; i++) begin
        check("m_cnt",   32'(cnt_of(i)), 32'(to_bcd(mc[i])));
        check("m_carry", 32'(cy[i]), 32'(enable & (up_dn ? (mc[i] == M[i] - 1) : (mc[i] == 0))));
        check("m_sel",   32'(sel[i]), 32'(5 - midx[i]));
        check("m_seg",   32'(seg[i]), 32'(mseg[i]));
      end
    end
  end

  // Park at a negedge whose following posedge is a count edge.
  task automatic to_tick_edge();
    for (int n = 0; n < 8 && (edge_n % 4) != 3; n++) @(negedge clk);
  endtask

  // Advance to the negedge just after the next count edge.
  task automatic tick();
    @(negedge clk);
    for (int n = 0; n < 8 && (edge_n % 4) != 0; n++) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] a, input logic [7:0] b, input logic [11:0] c);
    lv_a = a; lv_b = b; lv_c = c; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Wait for digit 0 of the 3-digit unit to be selected, then walk one frame.
  task automatic scan_frame(input string tag, input logic [6:0] s1, input logic [6:0] s2);
    bit found = 1'b0;
    for (int n = 0; n < 6 && !found; n++) begin
      @(negedge clk);
      if (sel[2] == 3'd5) found = 1'b1;
    end
    check({tag, "_found"}, 32'(found), 32'd1);
    check({tag, "_seg5"}, 32'(seg[2]), 32'(7'b1110000));
    repeat (2) @(negedge clk);
    check({tag, "_sel4"}, 32'(sel[2]), 32'd4);
    check({tag, "_seg4"}, 32'(seg[2]), 32'(s1));
    repeat (2) @(negedge clk);
    check({tag, "_sel3"}, 32'(sel[2]), 32'd3);
    check({tag, "_seg3"}, 32'(seg[2]), 32'(s2));
    repeat (2) @(negedge clk);
    check({tag, "_wrap"}, 32'(sel[2]), 32'd5);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; up_dn = 1'b1; load = 1'b0; blank_lz = 1'b0;
    lv_a = '0; lv_b = '0; lv_c = '0;
    repeat (2) @(negedge clk);

    // Reset state
    for (int i = 0; i < ND; i++) begin
      check("rst_cnt", 32'(cnt_of(i)), 32'd0);
      check("rst_sel", 32'(sel[i]), 32'd5);
      check("rst_seg", 32'(seg[i]), 32'(7'b1111110));
      check("rst_dpt", 32'(dpt[i]), 32'd0);
      check("rst_com", 32'(com[i]), 32'd1);
      check("rst_cy_dis", 32'(cy[i]), 32'd0);
    end
    enable = 1'b1; up_dn = 1'b0; #1;
    for (int i = 0; i < ND; i++) check("rst_cy_dn", 32'(cy[i]), 32'd1);
    up_dn = 1'b1; #1;
    for (int i = 0; i < ND; i++) check("rst_cy_up", 32'(cy[i]), 32'd0);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0; chk_on = 1'b1;

    // Load coincident with a count tick: load wins
    to_tick_edge();
    enable = 1'b1; up_dn = 1'b1;
    do_load(8'h42, 8'h42, 12'h042);
    enable = 1'b0;
    check("ld_tick_a", 32'(cnt_a), 32'h42);
    check("ld_tick_c", 32'(cnt_c), 32'h042);

    // Non-decimal digit loads zero; out-of-range for mod 60 loads zero
    do_load(8'h7A, 8'h75, 12'h999);
    check("ld_bad_a", 32'(cnt_a), 32'h00);
    check("ld_range_b", 32'(cnt_b), 32'h00);
    check("ld_max_c", 32'(cnt_c), 32'h999);

    // Up wrap, modulo 100
    do_load(8'h98, 8'h10, 12'h000);
    up_dn = 1'b1; enable = 1'b1; #1;
    check("up_cy98", 32'(cy[0]), 32'd0);
    tick();
    check("up_99", 32'(cnt_a), 32'h99);
    check("up_cy99", 32'(cy[0]), 32'd1);
    tick();
    check("up_00", 32'(cnt_a), 32'h00);
    check("up_cy00", 32'(cy[0]), 32'd0);

    // Down wrap, modulo 60
    enable = 1'b0;
    do_load(8'h50, 8'h01, 12'h001);
    up_dn = 1'b0; enable = 1'b1; #1;
    check("dn_cy01", 32'(cy[1]), 32'd0);
    tick();
    check("dn_00", 32'(cnt_b), 32'h00);
    check("dn_cy00", 32'(cy[1]), 32'd1);
    tick();
    check("dn_59", 32'(cnt_b), 32'h59);
    check("dn_cy59", 32'(cy[1]), 32'd0);
    check("dn_c999", 32'(cnt_c), 32'h999);

    // Scan and leading-zero blanking on the 3-digit unit
    enable = 1'b0; up_dn = 1'b1;
    do_load(8'h00, 8'h00, 12'h007);
    blank_lz = 1'b1;
    scan_frame("blank", 7'b0000000, 7'b0000000);
    blank_lz = 1'b0;
    scan_frame("noblank", 7'b1111110, 7'b1111110);

    // Enable off across 10 ticks
    do_load(8'h37, 8'h21, 12'h456);
    for (int k = 0; k < 10; k++) begin
      up_dn = k[0];
      tick();
      check("en_off_cnt", 32'(cnt_a), 32'h37);
      check("en_off_cy", 32'(cy[0]), 32'd0);
    end

    // Asynchronous reset mid-count
    up_dn = 1'b1; enable = 1'b1;
    do_load(8'h47, 8'h47, 12'h047);
    #3 reset = 1'b1;
    #1;
    check("arst_cnt", 32'(cnt_a), 32'h00);
    check("arst_sel", 32'(sel[0]), 32'd5);
    check("arst_seg", 32'(seg[0]), 32'(7'b1111110));
    @(negedge clk);
    reset = 1'b0;

    // Randomized run against the model
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) up_dn = ~up_dn;
      if ($urandom_range(0, 29) == 0) blank_lz = ~blank_lz;
      load = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 0) begin
        lv_a = 8'($urandom); lv_b = 8'($urandom); lv_c = 12'($urandom);
      end else begin
        lv_a = 8'h99; lv_b = 8'h59; lv_c = 12'($urandom_range(0, 1) ? 12'h999 : 12'h000);
      end
    end
    load = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      check("end_dpt", 32'(dpt[i]), 32'd0);
      check("end_com", 32'(com[i]), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
